// File: rtl/music_pkg.sv
// Shared audio constants and types for the DDS-to-codec output path.
// Slot-to-channel mapping lives here so every consumer agrees on frame layout.
package music_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int FRAME_SLOTS = 2 * SAMPLE_W;

    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

    // Observability bundle for the serialiser: slot position and FIFO state.
    typedef struct packed {
        logic [7:0] slot;
        logic       fifo_full;
        logic       fifo_empty;
    } i2s_dbg_t;

    // Word select leads each channel MSB by one bit clock.
    function automatic logic lrck_for_slot(input int slot, input int width);
        return ((slot >= width - 1) && (slot <= 2 * width - 2)) ? LRCK_RIGHT : LRCK_LEFT;
    endfunction

endpackage

// File: rtl/i2s_tx_sample_fifo2.sv
// Two-entry sample FIFO between the DDS sample strobe and the I2S frame loader.
// A push into a full FIFO is dropped unless a pop frees the head in the same cycle.
module sample_fifo2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic         drop
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    // Pop is judged on the registered state, so a same-cycle push never bypasses.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: mono DDS samples duplicated to both channels, bclk/lrck from clk.
// Build option I2S_MUTE_ON_UNDERFLOW_EN: send silence instead of the last sample on underflow.
module i2s_tx #(
    parameter int SAMPLE_W  = music_pkg::SAMPLE_W,
    parameter int BCLK_HALF = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_ready,
    output logic                bclk,
    output logic                lrck,
    output logic                sdata,
    output logic                underflow,
    output logic                overrun,
    output music_pkg::i2s_dbg_t dbg
);

    import music_pkg::*;

    localparam int FRAME  = 2 * SAMPLE_W;
    localparam int SLOT_W = $clog2(FRAME);
    localparam int DIV_W  = $clog2(BCLK_HALF);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic [SLOT_W-1:0]   slot;
    logic [SLOT_W-1:0]   slot_nxt;
    logic [SAMPLE_W-1:0] shreg;
    logic [SAMPLE_W-1:0] last;
    logic [SAMPLE_W-1:0] fallback;
    logic [SAMPLE_W-1:0] load_word;
    logic                wrap;
    logic                fall_evt;
    logic                frame_load;

    logic [SAMPLE_W-1:0] fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_drop;

    assign wrap       = en && (div_cnt == DIV_LAST);
    assign fall_evt   = wrap && bclk;
    assign frame_load = fall_evt && (slot == LAST_SLOT);
    assign slot_nxt   = (slot == LAST_SLOT) ? '0 : slot + 1'b1;

`ifdef I2S_MUTE_ON_UNDERFLOW_EN
    assign fallback = '0;
`else
    assign fallback = last;
`endif

    assign load_word = fifo_empty ? fallback : fifo_head;

    sample_fifo2 #(
        .W(SAMPLE_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (sample_ready),
        .push_data(sample),
        .pop      (frame_load),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .drop     (fifo_drop)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt   <= '0;
            bclk      <= 1'b0;
            slot      <= LAST_SLOT;
            shreg     <= '0;
            last      <= '0;
            lrck      <= LRCK_LEFT;
            sdata     <= 1'b0;
            underflow <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (fifo_drop) begin
                overrun <= 1'b1;
            end

            if (en) begin
                if (wrap) begin
                    div_cnt <= '0;
                    bclk    <= ~bclk;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            // Everything visible to the codec changes on the bclk falling edge.
            if (fall_evt) begin
                slot <= slot_nxt;
                lrck <= lrck_for_slot(int'(slot_nxt), SAMPLE_W);
                if (frame_load) begin
                    sdata <= load_word[SAMPLE_W-1];
                    shreg <= {load_word[SAMPLE_W-2:0], load_word[SAMPLE_W-1]};
                    if (fifo_empty) begin
                        underflow <= 1'b1;
                    end else begin
                        last <= fifo_head;
                    end
                end else begin
                    // Rotation brings the word back after SAMPLE_W bits for the right channel.
                    sdata <= shreg[SAMPLE_W-1];
                    shreg <= {shreg[SAMPLE_W-2:0], shreg[SAMPLE_W-1]};
                end
            end
        end
    end

    assign dbg.slot       = 8'(slot);
    assign dbg.fifo_full  = fifo_full;
    assign dbg.fifo_empty = fifo_empty;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: frame words are queued as samples are pushed and
// checked bit by bit against sdata/lrck as each frame is serialised.
module tb_i2s_tx;
  import music_pkg::*;

  localparam int W  = 16;
  localparam int BH = 4;

`ifdef I2S_MUTE_ON_UNDERFLOW_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [W-1:0] sample;
  logic         sample_ready;
  logic         bclk;
  logic         lrck;
  logic         sdata;
  logic         underflow;
  logic         overrun;
  i2s_dbg_t     dbg;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  // kind 0: push a sample; kind 1: freeze en for 50 clk
  typedef struct {
    int           slot;
    int           delay;
    int           kind;
    logic [W-1:0] val;
    bit           kept;
  } hook_t;
  hook_t hooks[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  i2s_tx #(
    .SAMPLE_W (W),
    .BCLK_HALF(BH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .sample      (sample),
    .sample_ready(sample_ready),
    .bclk        (bclk),
    .lrck        (lrck),
    .sdata       (sdata),
    .underflow   (underflow),
    .overrun     (overrun),
    .dbg         (dbg)
  );

  function automatic logic [W-1:0] fb(input logic [W-1:0] last_word);
    return MUTE ? '0 : last_word;
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_sample(input logic [W-1:0] v, input bit kept);
    sample       = v;
    sample_ready = 1'b1;
    if (kept) exp_q.push_back(v);
    @(negedge clk);
    sample_ready = 1'b0;
  endtask

  task automatic wait_slot(input int s, input string tag);
    int n = 0;
    while (dbg.slot != 8'(s) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check({tag, "_slot_timeout"}, 64'(dbg.slot), 64'(s));
  endtask

  task automatic freeze(input logic [W-1:0] w, input int s);
    repeat (2) @(negedge clk);
    en = 1'b0;
    push_sample(16'h5A5A, 1'b1);
    repeat (49) @(negedge clk);
    check("freeze_bclk", 64'(bclk), 64'(0));
    check("freeze_lrck", 64'(lrck), 64'(0));
    check("freeze_slot", 64'(dbg.slot), 64'(s));
    check("freeze_sdata", 64'(sdata), 64'(w[W-1-s]));
    en = 1'b1;
  endtask

  task automatic collect(input int last_slot, input string tag);
    logic [2*W-1:0] got_sd;
    logic [2*W-1:0] got_lr;
    logic [2*W-1:0] want_lr;
    logic [2*W-1:0] mask;
    logic [W-1:0]   w;
    hook_t          h;
    got_sd  = '0;
    got_lr  = '0;
    want_lr = '0;
    mask    = '0;
    w       = exp_q.pop_front();
    for (int s = 0; s <= last_slot; s++) begin
      wait_slot(s, tag);
      got_sd[2*W-1-s]  = sdata;
      got_lr[2*W-1-s]  = lrck;
      want_lr[2*W-1-s] = (s >= W - 1) && (s <= 2 * W - 2);
      mask[2*W-1-s]    = 1'b1;
      while (hooks.size() > 0 && hooks[0].slot == s) begin
        h = hooks.pop_front();
        repeat (h.delay) @(negedge clk);
        if (h.kind == 0) push_sample(h.val, h.kept);
        else freeze(w, s);
      end
    end
    check({tag, "_sdata"}, 64'(got_sd), 64'({w, w} & mask));
    check({tag, "_lrck"}, 64'(got_lr), 64'(want_lr));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset        = 1'b0;
    en           = 1'b0;
    sample_ready = 1'b0;
    sample       = '0;
    repeat (3) @(negedge clk);
    check("rst_bclk", 64'(bclk), 64'(0));
    check("rst_lrck", 64'(lrck), 64'(0));
    check("rst_sdata", 64'(sdata), 64'(0));
    check("rst_underflow", 64'(underflow), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    check("rst_slot", 64'(dbg.slot), 64'(31));
    check("rst_empty", 64'(dbg.fifo_empty), 64'(1));

    // release with en=1, push at clk 2, first fall event at clk 8
    reset = 1'b1;
    en    = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin
        sample       = 16'hA5C3;
        sample_ready = 1'b1;
        exp_q.push_back(16'hA5C3);
      end else begin
        sample_ready = 1'b0;
      end
      @(negedge clk);
      if (k == 3) check("clk3_bclk", 64'(bclk), 64'(0));
      if (k == 4) check("clk4_bclk", 64'(bclk), 64'(1));
      if (k == 7) check("clk7_slot", 64'(dbg.slot), 64'(31));
      if (k == 8) begin
        check("clk8_slot", 64'(dbg.slot), 64'(0));
        check("clk8_bclk", 64'(bclk), 64'(0));
        check("clk8_msb", 64'(sdata), 64'(1));
      end
    end

    hooks.push_back('{3, 0, 0, 16'h1234, 1'b1});
    collect(31, "f1");
    check("f1_underflow", 64'(underflow), 64'(0));

    collect(31, "f2");
    check("f2_underflow", 64'(underflow), 64'(0));
    check("f2_overrun", 64'(overrun), 64'(0));

    // empty FIFO at frame 3; three pushes during it, the third is dropped
    exp_q.push_back(fb(16'h1234));
    hooks.push_back('{2, 0, 0, 16'h1111, 1'b1});
    hooks.push_back('{3, 0, 0, 16'h2222, 1'b1});
    hooks.push_back('{4, 0, 0, 16'h3333, 1'b0});
    collect(31, "f3");
    check("f3_underflow", 64'(underflow), 64'(1));
    check("f3_overrun", 64'(overrun), 64'(1));

    collect(31, "f4");

    // push lands on the same clk as the slot-0 fall event of frame 6
    exp_q.push_back(fb(16'h2222));
    hooks.push_back('{31, 2 * BH - 1, 0, 16'h4B5A, 1'b1});
    collect(31, "f5");
    collect(31, "f6");
    check("f6_underflow", 64'(underflow), 64'(1));

    hooks.push_back('{7, 0, 1, 16'h0000, 1'b0});
    collect(31, "f7");

    // a sample left in the FIFO must be discarded by reset
    hooks.push_back('{10, 0, 0, 16'hF00F, 1'b0});
    collect(20, "f8");
    repeat (5) @(negedge clk);
    check("pre_rst_bclk", 64'(bclk), 64'(1));
    check("pre_rst_lrck", 64'(lrck), 64'(1));
    check("pre_rst_sdata", 64'(sdata), 64'(1));
    check("pre_rst_underflow", 64'(underflow), 64'(1));
    check("pre_rst_overrun", 64'(overrun), 64'(1));
    reset = 1'b0;
    #1;
    check("async_bclk", 64'(bclk), 64'(0));
    check("async_lrck", 64'(lrck), 64'(0));
    check("async_sdata", 64'(sdata), 64'(0));
    check("async_underflow", 64'(underflow), 64'(0));
    check("async_overrun", 64'(overrun), 64'(0));
    repeat (3) @(negedge clk);
    check("post_rst_empty", 64'(dbg.fifo_empty), 64'(1));
    check("post_rst_slot", 64'(dbg.slot), 64'(31));
    reset = 1'b1;

    exp_q.push_back(16'h0000);
    collect(31, "f9");
    check("f9_underflow", 64'(underflow), 64'(1));
    check("f9_overrun", 64'(overrun), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Audio output stage directly downstream of the DDS sine generator.
- Accepts each 16-bit sample qualified by the DDS one-cycle sample_ready pulse and buffers it in a 2-entry FIFO.
- Serialises samples as standard Philips I2S to the board DAC/codec. The mono sample is duplicated to the left and right channels.
- Generates bclk and lrck from the system clock.

Parameters:
- SAMPLE_W, 16: sample width and bits per channel slot.
- BCLK_HALF, 4: clk cycles per bclk half-period (legal range 2 or more); bclk = clk / (2*BCLK_HALF).

Ports:
- clk  input  1: system clock; all logic on rising edge.
- reset  input  1: asynchronous, active-low reset.
- en  input  1: run enable for the serialiser.
- sample  input  SAMPLE_W: signed PCM sample from DDS.
- sample_ready  input  1: one-cycle pulse; sample is valid in that cycle.
- bclk  output  1: I2S bit clock.
- lrck  output  1: word select; 0 = left, 1 = right.
- sdata  output  1: serial data, MSB first.
- underflow  output  1: sticky; a frame started with the FIFO empty.
- overrun  output  1: sticky; a push was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous): bclk=0, lrck=0, sdata=0, underflow=0, overrun=0, FIFO empty, div_cnt=0, slot=2*SAMPLE_W-1, shift register=0, last=0.
- Divider:
  - div_cnt counts 0..BCLK_HALF-1 while en=1.
  - At wrap, bclk toggles.
  - A fall event is a wrap while bclk=1.
  - en=0: div_cnt, bclk, slot and shift register hold their values. bclk stays frozen at its last value. The FIFO still accepts pushes.
- Slot counter:
  - slot advances on each fall event and wraps 2*SAMPLE_W-1 -> 0.
  - lrck, sdata and slot all update in the same clk cycle as the fall event, so they change on the bclk falling edge.
- lrck = 1 for slot in [SAMPLE_W-1, 2*SAMPLE_W-2], otherwise 0. lrck therefore leads each channel MSB by one bclk.
- Frame load, on the fall event into slot 0:
  - If the FIFO is non-empty: pop the head, load it into the shift register, and copy it to `last`.
  - If the FIFO is empty: set underflow and load the fallback word (see Optional Feature).
- sdata:
  - For slot s < SAMPLE_W: word bit (SAMPLE_W-1-s).
  - For s >= SAMPLE_W: the same word, bit (2*SAMPLE_W-1-s). The right channel repeats the left.
- FIFO:
  - 2 entries. Push on sample_ready=1.
  - Push while full: sample dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle: both occur. When full, this leaves the FIFO full with the new sample at the tail.
  - Push into an empty FIFO in the same cycle as a frame load: no bypass. The pop sees empty, so underflow is flagged and the pushed sample is stored for the next frame.
- Latency: a sample pushed at least 1 clk before the slot-0 fall event has its MSB on sdata from that event. Its LSB finishes 2*SAMPLE_W bclk periods later.
- Sticky flags clear only on reset.
- Reset mid-frame: all outputs go immediately to their reset values. The first frame after release begins at the first fall event.

Optional Feature:
- Macro: I2S_MUTE_ON_UNDERFLOW_EN.
- Defined: the underflow fallback word is 0 (silence).
- Undefined: the fallback word is `last`, the most recently popped sample (0 after reset).
- The underflow flag is set identically in both builds.

Decomposition:
- Shared package music_pkg:
  - SAMPLE_W default 16.
  - Frame length constant FRAME_SLOTS = 2*SAMPLE_W.
  - Channel encodings LRCK_LEFT=0 and LRCK_RIGHT=1.
- One sub-module, sample_fifo2:
  - 2-entry FIFO with push, pop, full, empty, head and a drop indication.
  - Instantiated once. The divider, slot counter and shift register stay in i2s_tx.

Test Plan:
- Reset release with en=1; push 16'hA5C3 at clk 2.
  - First fall event at clk 8.
  - sdata = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 over slots 0..15, then repeated in slots 16..31.
  - lrck rises at slot 15 and falls at slot 31.
  - underflow=0.
- Push 16'h1234, then no further pushes.
  - Frame 2 sets underflow=1.
  - Mute build: sdata all 0 for frame 2.
  - Non-mute build: frame 2 repeats 16'h1234.
- Push three samples within one frame while the FIFO is empty.
  - overrun=1.
  - The next two frames carry samples 1 and 2; the third sample is lost.
- Push timed on the same clk as the slot-0 fall event with the FIFO empty.
  - underflow=1 for that frame.
  - The pushed sample appears in the next frame.
- en=0 for 50 clk mid-frame (slot 7).
  - bclk, lrck and sdata frozen; slot stays 7.
  - After en=1, the frame resumes at slot 7 with no bits lost.
- Assert reset at slot 20.
  - bclk, lrck, sdata and both flags go to 0 asynchronously, before the next clk edge.
  - FIFO empty after release.
